// File: rtl/conv_line_buffer.sv
// Streaming line buffer and KxK window generator feeding the convolution multiplier.
// Pixels arrive in raster order; valid-only windows are presented once a full neighbourhood exists.
module conv_line_buffer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [BITS-1:0]                         pixel_in,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_out,
  output logic                                    win_valid,
  input  logic                                    win_ready,
  output logic                                    frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [BITS-1:0] line_buf [K-1][IMG_WIDTH];
  logic [BITS-1:0] win      [K][K];
  logic [BITS-1:0] slice    [K];
  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            window_pos;

  assign in_ready   = !win_valid || win_ready;
  assign accept     = in_valid && in_ready;
  assign col_last   = (col == CW'(IMG_WIDTH - 1));
  assign row_last   = (row == RW'(IMG_HEIGHT - 1));
  assign window_pos = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  // Vertical slice for the new right column: oldest line on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      slice[r] = line_buf[K-2-r][IMG_WIDTH-1];
    end
    slice[K-1] = pixel_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        win_valid <= window_pos;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  // Cascaded row buffers; data left over from a previous frame is masked by the position counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K - 1; i++) begin
        for (int j = 0; j < IMG_WIDTH; j++) begin
          line_buf[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < K - 1; i++) begin
        for (int j = 1; j < IMG_WIDTH; j++) begin
          line_buf[i][j] <= line_buf[i][j-1];
        end
        if (i == 0) begin
          line_buf[i][0] <= pixel_in;
        end else begin
          line_buf[i][0] <= line_buf[i-1][IMG_WIDTH-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= slice[r];
      end
    end
  end

  for (genvar gr = 0; gr < K; gr++) begin : g_pack_row
    for (genvar gc = 0; gc < K; gc++) begin : g_pack_col
      assign window_out[(gr*K+gc)*BITS +: BITS] = win[gr][gc];
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer on a 4x4 frame with a 3x3 kernel.
// A raster-position model builds every expected window independently of the design.
module tb_conv_line_buffer;

  localparam int BITS = 9;
  localparam int K    = 3;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int WB   = K * K * BITS;

  logic            clk = 1'b0;
  logic            reset;
  logic [BITS-1:0] pixel_in;
  logic            in_valid;
  logic            in_ready;
  logic [WB-1:0]   window_out;
  logic            win_valid;
  logic            win_ready;
  logic            frame_done;

  int              checks = 0;
  int              failures = 0;
  logic [WB-1:0]   exp_q [$];
  logic [BITS-1:0] img [H][W];
  int              mrow = 0;
  int              mcol = 0;
  int              win_seen = 0;
  int              fd_seen = 0;
  int              stall_cycles = 0;
  bit              bp_arm = 1'b0;
  int              bp_left = 0;

  conv_line_buffer #(
    .BITS(BITS), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .in_ready(in_ready), .window_out(window_out), .win_valid(win_valid),
    .win_ready(win_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Downstream ready: normally high, dropped for 5 cycles once an armed stall sees a window.
  always @(posedge clk) begin
    #1;
    if (bp_arm && win_valid) begin
      bp_arm  = 1'b0;
      bp_left = 5;
    end
    if (bp_left > 0) begin
      win_ready = 1'b0;
      bp_left--;
    end else begin
      win_ready = 1'b1;
    end
  end

  // Output monitor: every presented window must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) fd_seen++;
      if (win_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_window got=%h required=none", window_out);
        end else begin
          if (window_out !== exp_q[0]) begin
            failures++;
            $display("[TB] FAIL window got=%h required=%h", window_out, exp_q[0]);
          end
          if (win_ready) begin
            void'(exp_q.pop_front());
            win_seen++;
          end else begin
            stall_cycles++;
            checks++;
            if (in_ready !== 1'b0) begin
              failures++;
              $display("[TB] FAIL in_ready_stall got=%b required=0", in_ready);
            end
          end
        end
      end
    end
  end

  task automatic model_accept(input logic [BITS-1:0] v);
    logic [WB-1:0] e;
    e = '0;
    img[mrow][mcol] = v;
    if (mrow >= K - 1 && mcol >= K - 1) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          e[(r*K+c)*BITS +: BITS] = img[mrow-K+1+r][mcol-K+1+c];
        end
      end
      exp_q.push_back(e);
    end
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  task automatic drive_pixel(input logic [BITS-1:0] v, input int gap_max);
    int gap;
    int guard;
    gap   = $urandom_range(gap_max, 0);
    guard = 0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    pixel_in = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout got=0 required=1");
    end
    model_accept(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_and_check(input string name, input int start, input int want);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (win_seen - start !== want) begin
      failures++;
      $display("[TB] FAIL %s_window_count got=%0d required=%0d", name, win_seen - start, want);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL %s_pending got=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    checks++;
    if (win_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_win_valid got=%b required=0", win_valid);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_frame_done got=%b required=0", frame_done);
    end
    checks++;
    if (window_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_window_out got=%h required=0", window_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready);
    end
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
  endtask

  task automatic test_fill();
    int start;
    start = win_seen;
    for (int i = 0; i < W * H; i++) begin
      drive_pixel(BITS'(i), 0);
      if (i == 9) begin
        checks++;
        if (win_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL fill_early_valid got=%b required=0", win_valid);
        end
      end
      if (i == 10) begin
        checks++;
        if (win_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL fill_latency got=%b required=1", win_valid);
        end
      end
    end
    drain_and_check("fill", start, 4);
  endtask

  task automatic test_backpressure();
    int start;
    int stall0;
    start  = win_seen;
    stall0 = stall_cycles;
    bp_arm = 1'b1;
    for (int i = 0; i < W * H; i++) drive_pixel(BITS'(i), 0);
    drain_and_check("backpressure", start, 4);
    checks++;
    if (stall_cycles - stall0 !== 5) begin
      failures++;
      $display("[TB] FAIL backpressure_stall_cycles got=%0d required=5", stall_cycles - stall0);
    end
  endtask

  task automatic test_gaps();
    int start;
    start = win_seen;
    for (int i = 0; i < W * H; i++) drive_pixel(BITS'(i), 2);
    drain_and_check("gaps", start, 4);
  endtask

  task automatic test_frame_wrap();
    int start;
    int fd0;
    start = win_seen;
    fd0   = fd_seen;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        drive_pixel(BITS'(f * 100 + i), 0);
        if (i == W * H - 1) begin
          checks++;
          if (frame_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frame_done_pulse frame=%0d got=%b required=1", f, frame_done);
          end
        end
      end
    end
    drain_and_check("frame_wrap", start, 8);
    checks++;
    if (fd_seen - fd0 !== 2) begin
      failures++;
      $display("[TB] FAIL frame_done_count got=%0d required=2", fd_seen - fd0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int start;
    for (int i = 0; i < 10; i++) drive_pixel(BITS'(i), 0);
    reset_dut();
    start = win_seen;
    for (int i = 0; i < W * H; i++) drive_pixel(BITS'(i), 0);
    drain_and_check("reset_mid", start, 4);
  endtask

  task automatic test_max_values();
    int start;
    start = win_seen;
    for (int i = 0; i < W * H; i++) begin
      drive_pixel(9'h1FF, 0);
      if (i == 10) begin
        checks++;
        if (window_out !== {WB{1'b1}}) begin
          failures++;
          $display("[TB] FAIL max_window got=%h required=all ones", window_out);
        end
      end
    end
    drain_and_check("max", start, 4);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    pixel_in  = '0;
    win_ready = 1'b1;
    test_reset();
    test_fill();
    test_backpressure();
    test_gaps();
    test_frame_wrap();
    test_reset_mid_frame();
    test_max_values();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
